bus_timer: RTL and testbench

//  Memory-mapped 16-bit down-counting timer; the peripheral that produces int_timer for the CPU's int[0] line.

---
 rtl/bus_timer_pkg.sv | 39 +++
 rtl/bus_timer_prescaler.sv | 30 +++
 rtl/bus_timer.sv | 163 ++++++++++++++++
 tb/tb_bus_timer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer peripheral: data width, register offsets and CTRL/STATUS bit positions.
// The optional PWM channel is enabled by defining TIMER_PWM_EN.
package bus_timer_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned OFF_W          = 3;
    localparam int unsigned TIMER_NUM_REGS = 6;

    typedef enum logic [OFF_W-1:0] {
        TIMER_CTRL   = 3'd0,
        TIMER_LOAD   = 3'd1,
        TIMER_COUNT  = 3'd2,
        TIMER_PSC    = 3'd3,
        TIMER_STATUS = 3'd4,
        TIMER_CMP    = 3'd5
    } timer_reg_e;

    localparam int unsigned TIMER_EN_BIT = 0;
    localparam int unsigned TIMER_AR_BIT = 1;
    localparam int unsigned TIMER_IE_BIT = 2;
    localparam int unsigned TIMER_IF_BIT = 0;

    typedef struct packed {
        logic ie;
        logic ar;
        logic en;
    } timer_ctrl_t;

    // CTRL register as seen on the bus; unmapped bits read 0
    function automatic logic [DATA_W-1:0] ctrl_to_word(input timer_ctrl_t c);
        logic [DATA_W-1:0] w;
        w               = '0;
        w[TIMER_EN_BIT] = c.en;
        w[TIMER_AR_BIT] = c.ar;
        w[TIMER_IE_BIT] = c.ie;
        return w;
    endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for bus_timer: psc_cnt runs 0..psc while enabled and pulses tick on the terminal value.
module timer_prescaler
    import bus_timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] psc,
    output logic              tick
);

    logic [DATA_W-1:0] r_cnt;
    logic              w_wrap;

    assign w_wrap = (r_cnt == psc);
    assign tick   = en & w_wrap;

    // held at 0 while disabled so a fresh enable always starts a full prescale period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en || clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DATA_W'(1);
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 16-bit down-counting timer with level interrupt on underflow (int_timer).
// Defining TIMER_PWM_EN adds the CMP register and the pwm_out output.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR = 16'hFF10,
    parameter logic [DATA_W-1:0] PSC_RST   = 16'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] addr,
    input  logic              ctrl,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              sel,
    output logic              int_timer
`ifdef TIMER_PWM_EN
    ,
    output logic              pwm_out
`endif
);

    logic [DATA_W-1:0] r_load;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_psc;
    timer_ctrl_t       r_ctrl;
    logic              r_if;
    logic              r_int;

    logic [DATA_W-1:0] w_off_full;
    timer_reg_e        w_reg;
    logic              w_wr;
    logic              w_wr_ctrl;
    logic              w_wr_load;
    logic              w_wr_psc;
    logic              w_wr_status;
    logic              w_psc_clr;
    logic              w_tick;
    logic              w_fire;
    logic              w_underflow;

    // address decode
    assign w_off_full = addr - BASE_ADDR;
    assign sel        = (addr >= BASE_ADDR) && (w_off_full < DATA_W'(TIMER_NUM_REGS));
    assign w_reg      = timer_reg_e'(w_off_full[OFF_W-1:0]);

    assign w_wr        = ctrl & sel;
    assign w_wr_ctrl   = w_wr && (w_reg == TIMER_CTRL);
    assign w_wr_load   = w_wr && (w_reg == TIMER_LOAD);
    assign w_wr_psc    = w_wr && (w_reg == TIMER_PSC);
    assign w_wr_status = w_wr && (w_reg == TIMER_STATUS);

    // LOAD writes and EN rising edges restart the prescale period
    assign w_psc_clr = w_wr_load | (w_wr_ctrl & wdata[TIMER_EN_BIT] & ~r_ctrl.en);

    timer_prescaler u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_ctrl.en),
        .clr  (w_psc_clr),
        .psc  (r_psc),
        .tick (w_tick)
    );

    // a LOAD write or a CTRL write clearing EN takes precedence over a coincident tick
    assign w_fire      = w_tick & ~w_wr_load & ~(w_wr_ctrl & ~wdata[TIMER_EN_BIT]);
    assign w_underflow = w_fire & (r_count == '0);

`ifdef TIMER_PWM_EN
    logic              w_wr_cmp;
    logic [DATA_W-1:0] r_cmp;
    logic              r_pwm;

    assign w_wr_cmp = w_wr && (w_reg == TIMER_CMP);
    assign pwm_out  = r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp <= '0;
            r_pwm <= 1'b0;
        end else begin
            if (w_wr_cmp) begin
                r_cmp <= wdata;
            end
            r_pwm <= (r_count < r_cmp) & r_ctrl.en;
        end
    end
`endif

    // read mux
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (w_reg)
                TIMER_CTRL:   rdata = ctrl_to_word(r_ctrl);
                TIMER_LOAD:   rdata = r_load;
                TIMER_COUNT:  rdata = r_count;
                TIMER_PSC:    rdata = r_psc;
                TIMER_STATUS: rdata = {{(DATA_W-1){1'b0}}, r_if};
`ifdef TIMER_PWM_EN
                TIMER_CMP:    rdata = r_cmp;
`endif
                default:      rdata = '0;
            endcase
        end
    end

    // configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load <= '0;
            r_psc  <= PSC_RST;
            r_ctrl <= '0;
        end else begin
            if (w_wr_load) begin
                r_load <= wdata;
            end
            if (w_wr_psc) begin
                r_psc <= wdata;
            end
            if (w_wr_ctrl) begin
                r_ctrl.en <= wdata[TIMER_EN_BIT];
                r_ctrl.ar <= wdata[TIMER_AR_BIT];
                r_ctrl.ie <= wdata[TIMER_IE_BIT];
            end else if (w_underflow && !r_ctrl.ar) begin
                r_ctrl.en <= 1'b0;
            end
        end
    end

    // down counter: reload on auto-reload underflow, park at 0 for one-shot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_wr_load) begin
            r_count <= wdata;
        end else if (w_fire) begin
            if (r_count != '0) begin
                r_count <= r_count - DATA_W'(1);
            end else if (r_ctrl.ar) begin
                r_count <= r_load;
            end
        end
    end

    // interrupt flag; a new underflow beats a simultaneous W1C
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if  <= 1'b0;
            r_int <= 1'b0;
        end else begin
            if (w_underflow) begin
                r_if <= 1'b1;
            end else if (w_wr_status && wdata[TIMER_IF_BIT]) begin
                r_if <= 1'b0;
            end
            r_int <= r_if & r_ctrl.ie;
        end
    end

    assign int_timer = r_int;

endmodule

// File: tb/tb_bus_timer.sv
// Randomized plus directed bench for bus_timer against a cycle-level behavioural model of the register map.
module tb_bus_timer;

    localparam logic [15:0] BASE    = 16'hFF10;
    localparam logic [15:0] PSC_DEF = 16'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        ctrl;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        sel;
    logic        int_timer;
`ifdef TIMER_PWM_EN
    logic        pwm_out;
`endif

    always #5 clk = ~clk;

    bus_timer #(.BASE_ADDR(BASE), .PSC_RST(PSC_DEF)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .ctrl      (ctrl),
        .wdata     (wdata),
        .rdata     (rdata),
        .sel       (sel),
        .int_timer (int_timer)
`ifdef TIMER_PWM_EN
        ,
        .pwm_out   (pwm_out)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic        m_en, m_ar, m_ie, m_if, m_irq, m_pwm;
    logic [15:0] m_load, m_count, m_psc, m_pc, m_cmp;

    logic [15:0] last_rdata;
    logic        last_sel, last_int, last_pwm;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic m_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_if = 0; m_irq = 0; m_pwm = 0;
        m_load = 0; m_count = 0; m_psc = PSC_DEF; m_pc = 0; m_cmp = 0;
    endtask

    function automatic logic m_sel(input logic [15:0] a);
        return (a >= BASE) && (a <= BASE + 16'd5);
    endfunction

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        if (!m_sel(a)) return 16'd0;
        case (a - BASE)
            16'd0: return {13'd0, m_ie, m_ar, m_en};
            16'd1: return m_load;
            16'd2: return m_count;
            16'd3: return m_psc;
            16'd4: return {15'd0, m_if};
`ifdef TIMER_PWM_EN
            16'd5: return m_cmp;
`endif
            default: return 16'd0;
        endcase
    endfunction

    // one clock edge of the register-map rules, applied to the pre-edge state
    task automatic m_step(input logic [15:0] a, input logic c, input logic [15:0] d);
        logic        we, lw, cw, sw, tick, fire, uf;
        logic [15:0] off, n_count, n_pc;
        logic        n_en, n_if;
        off  = a - BASE;
        we   = c && m_sel(a);
        lw   = we && off == 16'd1;
        cw   = we && off == 16'd0;
        sw   = we && off == 16'd4;
        tick = m_en && (m_pc == m_psc);
        fire = tick && !lw && !(cw && !d[0]);
        uf   = fire && (m_count == 16'd0);

        if (!m_en || lw) n_pc = 16'd0;
        else n_pc = (m_pc == m_psc) ? 16'd0 : m_pc + 16'd1;

        n_count = m_count;
        if (lw) n_count = d;
        else if (fire) n_count = (m_count != 0) ? m_count - 16'd1 : (m_ar ? m_load : 16'd0);

        n_en = cw ? d[0] : ((uf && !m_ar) ? 1'b0 : m_en);
        n_if = uf ? 1'b1 : ((sw && d[0]) ? 1'b0 : m_if);

        m_irq = m_if && m_ie;
        m_pwm = (m_count < m_cmp) && m_en;
        if (cw) begin m_ar = d[1]; m_ie = d[2]; end
        if (lw) m_load = d;
        if (we && off == 16'd3) m_psc = d;
`ifdef TIMER_PWM_EN
        if (we && off == 16'd5) m_cmp = d;
`endif
        m_en = n_en; m_if = n_if; m_count = n_count; m_pc = n_pc;
    endtask

    // drive one bus cycle, check outputs mid-cycle, then advance the model at the edge
    task automatic cyc(input logic [15:0] a, input logic c, input logic [15:0] d);
        addr = a; ctrl = c; wdata = d;
        @(negedge clk);
        last_rdata = rdata; last_sel = sel; last_int = int_timer;
        chk("rdata", rdata, m_rd(a));
        chk("sel", 16'(sel), 16'(m_sel(a)));
        chk("int_timer", 16'(int_timer), 16'(m_irq));
`ifdef TIMER_PWM_EN
        last_pwm = pwm_out;
        chk("pwm_out", 16'(pwm_out), 16'(m_pwm));
`else
        last_pwm = 1'b0;
`endif
        @(posedge clk);
        m_step(a, c, d);
        #1;
    endtask

    initial begin
        logic        found;
        logic [15:0] hold;
        int          k;

        // reset state
        rst = 1'b1; addr = BASE + 16'd3; ctrl = 1'b0; wdata = 16'd0;
        m_reset();
        #3;
        chk("rst_psc", rdata, PSC_DEF);
        chk("rst_int", 16'(int_timer), 16'd0);
        addr = BASE;
        #1;
        chk("rst_ctrl", rdata, 16'd0);
        chk("rst_sel", 16'(sel), 16'd1);
        #8 rst = 1'b0;

        // 1: PSC=0, LOAD=3, auto-reload with interrupt
        cyc(BASE + 16'd3, 1, 16'd0);
        cyc(BASE + 16'd1, 1, 16'd3);
        cyc(BASE,         1, 16'd7);
        cyc(BASE + 16'd2, 0, 16'd0); chk("t1_c3", last_rdata, 16'd3);
        cyc(BASE + 16'd2, 0, 16'd0); chk("t1_c2", last_rdata, 16'd2);
        cyc(BASE + 16'd2, 0, 16'd0); chk("t1_c1", last_rdata, 16'd1);
        cyc(BASE + 16'd2, 0, 16'd0); chk("t1_c0", last_rdata, 16'd0);
        cyc(BASE + 16'd2, 0, 16'd0); chk("t1_reload", last_rdata, 16'd3);
        chk("t1_int_lag", 16'(last_int), 16'd0);
        cyc(BASE + 16'd4, 0, 16'd0); chk("t1_if", last_rdata, 16'd1);
        chk("t1_int", 16'(last_int), 16'd1);

        // 2: one-shot with PSC=4, LOAD=1
        cyc(BASE,         1, 16'd0);
        cyc(BASE + 16'd4, 1, 16'd1);
        cyc(BASE + 16'd3, 1, 16'd4);
        cyc(BASE + 16'd1, 1, 16'd1);
        cyc(BASE,         1, 16'd1);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc(BASE + 16'd4, 0, 16'd0);
            if (rdata[0]) begin k = i; break; end
        end
        chk("t2_period", 16'(k), 16'd10);
        cyc(BASE,         0, 16'd0); chk("t2_en_off", last_rdata, 16'd0);
        cyc(BASE + 16'd2, 0, 16'd0); chk("t2_cnt0", last_rdata, 16'd0);
        cyc(BASE + 16'd4, 1, 16'd1);
        for (int i = 0; i < 12; i++) cyc(BASE + 16'd4, 0, 16'd0);
        chk("t2_no_if", last_rdata, 16'd0);

        // 3: W1C colliding with an underflow, then a clean W1C
        cyc(BASE + 16'd3, 1, 16'd0);
        cyc(BASE + 16'd1, 1, 16'd2);
        cyc(BASE,         1, 16'd7);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_if && m_count == 16'd0 && m_en) found = 1'b1;
            else cyc(BASE + 16'd2, 0, 16'd0);
        end
        chk("t3_reach", 16'(found), 16'd1);
        cyc(BASE + 16'd4, 1, 16'd1);
        cyc(BASE + 16'd4, 0, 16'd0); chk("t3_set_wins", last_rdata, 16'd1);
        cyc(BASE,         1, 16'd4);
        cyc(BASE + 16'd4, 1, 16'd1);
        cyc(BASE + 16'd4, 0, 16'd0); chk("t3_if_clr", last_rdata, 16'd0);
        chk("t3_int_hold", 16'(last_int), 16'd1);
        cyc(BASE + 16'd4, 0, 16'd0); chk("t3_int_fall", 16'(last_int), 16'd0);

        // 4: disable on a tick edge, out-of-window reads
        cyc(BASE + 16'd3, 1, 16'd1);
        cyc(BASE + 16'd1, 1, 16'd50);
        cyc(BASE,         1, 16'd3);
        for (int i = 0; i < 5; i++) cyc(BASE + 16'd2, 0, 16'd0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (m_en && m_pc == m_psc) found = 1'b1;
            else cyc(BASE + 16'd2, 0, 16'd0);
        end
        chk("t4_reach", 16'(found), 16'd1);
        hold = m_count;
        cyc(BASE,         1, 16'd0);
        cyc(BASE + 16'd2, 0, 16'd0); chk("t4_hold", last_rdata, hold);
        cyc(BASE + 16'd7, 0, 16'd0);
        chk("t4_oor_rdata", last_rdata, 16'd0);
        chk("t4_oor_sel", 16'(last_sel), 16'd0);
        cyc(BASE - 16'd1, 0, 16'd0); chk("t4_below_sel", 16'(last_sel), 16'd0);

        // 5: asynchronous reset mid-count with the interrupt asserted
        cyc(BASE + 16'd3, 1, 16'd0);
        cyc(BASE + 16'd1, 1, 16'd1);
        cyc(BASE,         1, 16'd7);
        for (int i = 0; i < 4; i++) cyc(BASE + 16'd2, 0, 16'd0);
        cyc(BASE + 16'd1, 1, 16'd100);
        for (int i = 0; i < 3; i++) cyc(BASE + 16'd2, 0, 16'd0);
        chk("t5_pre_int", 16'(int_timer), 16'd1);
        #2;
        rst = 1'b1; addr = BASE + 16'd2; ctrl = 1'b0;
        #1;
        chk("t5_count", rdata, 16'd0);
        chk("t5_int", 16'(int_timer), 16'd0);
        addr = BASE;
        #1;
        chk("t5_ctrl", rdata, 16'd0);
        m_reset();
        #1 rst = 1'b0;
        #1;

`ifdef TIMER_PWM_EN
        // 6: PWM duty 3 of 10
        cyc(BASE + 16'd1, 1, 16'd9);
        cyc(BASE + 16'd5, 1, 16'd3);
        cyc(BASE,         1, 16'd3);
        for (int i = 0; i < 12; i++) cyc(BASE + 16'd2, 0, 16'd0);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(BASE + 16'd2, 0, 16'd0);
            if (last_pwm) k++;
        end
        chk("t6_duty", 16'(k), 16'd3);
        cyc(BASE, 1, 16'd0);
`endif

        // randomized register traffic
        for (int n = 0; n < 1500; n++) begin
            int unsigned op;
            int unsigned ko;
            logic [15:0] a, d;
            logic        c;
            op = $urandom_range(0, 9);
            a  = BASE + 16'($urandom_range(0, 7));
            c  = 1'b0;
            d  = 16'($urandom);
            case (op)
                0: begin
                    a = BASE; c = 1'b1;
                    d = 16'($urandom) & 16'hFFF8;
                    d[2:0] = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                end
                1: begin a = BASE + 16'd1; c = 1'b1; d = 16'($urandom_range(0, 6)); end
                2: begin a = BASE + 16'd3; c = 1'b1; d = 16'($urandom_range(0, 3)); end
                3: begin a = BASE + 16'd4; c = 1'b1; end
                4: begin
                    ko = $urandom_range(0, 3);
                    a = BASE + ((ko == 0) ? 16'd2 : 16'(ko + 4));
                    c = 1'b1;
                    if (ko == 1) d = 16'($urandom_range(0, 7));
                end
                5: begin a = 16'($urandom); c = 1'($urandom_range(0, 1)); end
                default: ;
            endcase
            cyc(a, c, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
